// File: rtl/mat_out_fifo_pkg.sv
// Shared matrix-accelerator parameters, also used by mat_mul.
// Provides the default matrix dimension (log2), the word width and
// the derived words-per-matrix values.
package mat_out_fifo_pkg;

  localparam int MAT_DIM_LOG    = 1;
  localparam int MAT_DATA_WIDTH = 32;
  localparam int MAT_SIZE_LOG   = 2 * MAT_DIM_LOG;
  localparam int MAT_SIZE       = 2 ** MAT_SIZE_LOG;

  // A DIM x DIM matrix holds 2**(2*DIM_LOG) words.
  function automatic int size_log(input int dim_log);
    return 2 * dim_log;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for mat_out_fifo.
// One synchronous write port and one asynchronous read port, so the
// read side can present the head word in the same cycle its address
// is known (first-word-fall-through). Maps onto LUTRAM.
//   i_clk            clock
//   i_we/i_waddr/i_wdata   write port
//   i_raddr/o_rdata        read port
module fifo_ram #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mat_out_fifo.sv
// Result FIFO between mat_mul (AXI-Stream slave side) and the DMA
// (AXI-Stream master side). Holds two full result matrices, regenerates
// tlast from its own output word count and flags upstream framing errors.
//   s00_axi_aclk / s00_axi_aresetn   clock, async active-low reset
//   s00_axis_*                       input stream from mat_mul
//   m00_axis_*                       output stream to DMA
//   err_clr / frame_err              sticky framing-error flag and clear
//   level                            words currently stored
//   frames_out                       completed output matrices, mod 256
module mat_out_fifo
  import mat_out_fifo_pkg::*;
#(
  parameter  int DIM_LOG    = MAT_DIM_LOG,
  parameter  int DATA_WIDTH = MAT_DATA_WIDTH,
  localparam int SIZE_LOG   = size_log(DIM_LOG),
  localparam int SIZE       = 2 ** SIZE_LOG,
  localparam int DEPTH_LOG  = SIZE_LOG + 1,
  localparam int DEPTH      = 2 ** DEPTH_LOG
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                    m00_axis_tvalid,
  output logic                    m00_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  input  logic                    m00_axis_tready,
  input  logic                    err_clr,
  output logic                    frame_err,
  output logic [DEPTH_LOG:0]      level,
  output logic [7:0]              frames_out
);

  localparam logic [DEPTH_LOG-1:0] PTR_ONE = {{(DEPTH_LOG-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG:0]   LVL_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};
  localparam logic [SIZE_LOG-1:0]  CNT_ONE = {{(SIZE_LOG-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG-1:0]  r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG:0]    r_level, w_level_nxt;
  logic [SIZE_LOG-1:0]   r_in_cnt, r_out_cnt;
  logic [7:0]            r_frames;
  logic                  r_err, r_rdy;
  logic                  w_push, w_pop, w_valid, w_last_out, w_fr_err;
  logic [DATA_WIDTH-1:0] w_rdata;

  // SIZE is a power of two, so SIZE-1 is all ones and counters wrap
  // for free.
  assign w_valid    = (r_level != '0);
  assign w_push     = s00_axis_tvalid & r_rdy;
  assign w_pop      = w_valid & m00_axis_tready;
  assign w_last_out = w_valid & (r_out_cnt == '1);
  assign w_fr_err   = w_push & (s00_axis_tlast != (r_in_cnt == '1));

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_frames  <= '0;
      r_err     <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        r_in_cnt <= r_in_cnt + CNT_ONE;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_out_cnt <= r_out_cnt + CNT_ONE;
        if (w_last_out) r_frames <= r_frames + 8'd1;
      end
      r_level <= w_level_nxt;
      // Level never exceeds DEPTH, so its MSB alone means "full".
      // Registered so tready has no path from m00_axis_tready.
      r_rdy   <= ~w_level_nxt[DEPTH_LOG];
      // Set has priority over clear.
      if (w_fr_err)     r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  fifo_ram #(
    .ADDR_W (DEPTH_LOG),
    .DATA_W (DATA_WIDTH)
  ) u_ram (
    .i_clk   (s00_axi_aclk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (s00_axis_tdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Stale RAM contents are masked so an empty FIFO (and reset) shows 0.
  assign m00_axis_tdata  = w_valid ? w_rdata : '0;
  assign m00_axis_tvalid = w_valid;
  assign m00_axis_tlast  = w_last_out;
  assign m00_axis_tstrb  = '1;
  assign s00_axis_tready = r_rdy;
  assign level           = r_level;
  assign frames_out      = r_frames;
  assign frame_err       = r_err;

endmodule

// File: tb/tb_mat_out_fifo.sv
module tb_mat_out_fifo;

  localparam int DW    = 32;
  localparam int SIZE  = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready = 1'b0;
  logic [3:0]    m_tstrb;
  logic          err_clr = 1'b0, frame_err;
  logic [3:0]    level;
  logic [7:0]    frames_out;

  always #5 clk = ~clk;

  mat_out_fifo dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tready (m_tready),
    .err_clr         (err_clr),
    .frame_err       (frame_err),
    .level           (level),
    .frames_out      (frames_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus word/frame counts.
  logic [DW-1:0] q[$];
  int  in_idx = 0, out_idx = 0, frames = 0;
  bit  err = 0, rdy_ok = 0;

  // Monitor: compare DUT against the model, then advance the model by
  // what the coming rising edge will do.
  always @(negedge clk) begin : mon
    bit exp_rdy, exp_v, pop, push, e;
    if (!rst_n) begin
      q.delete();
      in_idx = 0; out_idx = 0; frames = 0; err = 0; rdy_ok = 0;
      chk("rst_level", level, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_tdata", m_tdata, 0);
    end else begin
      exp_rdy = rdy_ok && (q.size() < DEPTH);
      exp_v   = (q.size() != 0);
      chk("tready", s_tready, exp_rdy);
      chk("level", level, q.size());
      chk("tvalid", m_tvalid, exp_v);
      if (exp_v) begin
        chk("tdata", m_tdata, q[0]);
        chk("tlast", m_tlast, (out_idx % SIZE) == SIZE - 1);
      end else begin
        chk("tdata_idle", m_tdata, 0);
        chk("tlast_idle", m_tlast, 0);
      end
      chk("frame_err", frame_err, err);
      chk("frames_out", frames_out, frames % 256);
      chk("tstrb", m_tstrb, 4'hf);
      pop  = exp_v && m_tready;
      push = s_tvalid && exp_rdy;
      e    = 0;
      if (pop) begin
        void'(q.pop_front());
        if ((out_idx % SIZE) == SIZE - 1) frames++;
        out_idx++;
      end
      if (push) begin
        e = (s_tlast != ((in_idx % SIZE) == SIZE - 1));
        q.push_back(s_tdata);
        in_idx++;
      end
      err    = e ? 1'b1 : (err_clr ? 1'b0 : err);
      rdy_ok = 1;
    end
  end

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit l,
                     input bit r, input bit c);
    @(posedge clk);
    #1;
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = r;
    err_clr  = c;
  endtask

  task automatic idle(input bit r);
    // Garbage data/tlast while tvalid=0 must be ignored.
    cyc(1'b0, $urandom, 1'($urandom), r, 1'b0);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) idle(1'b1);
    idle(1'b1);
    chk("drain_level", level, 0);
  endtask

  initial begin
    // Reset, then one edge for tready to rise.
    repeat (3) idle(1'b0);
    rst_n = 1'b1;
    idle(1'b0);
    idle(1'b0);

    // Single frame, sink always ready.
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(i + 1), i == 3, 1'b1, 1'b0);
    drain();
    chk("frames_after_first", frames_out, 1);

    // Sink stalled: 10 offered, 8 fit; then release.
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'(100 + i), (i % 4) == 3, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    chk("full_level", level, 8);
    chk("full_tready", s_tready, 0);
    drain();
    chk("frames_after_full", frames_out, 3);

    // Steady push+pop at level 3.
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(200 + i), (i % 4) == 3, 1'b0, 1'b0);
    for (int i = 3; i < 24; i++) cyc(1'b1, DW'(200 + i), (i % 4) == 3, 1'b1, 1'b0);
    idle(1'b0);
    chk("steady_level", level, 3);
    drain();

    // Framing errors: bad tlast together with err_clr (set wins),
    // then tlast on 3rd word, then a standalone clear.
    cyc(1'b1, 32'd300, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 32'd301, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'd302, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'd303, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'd304, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'd305, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'd306, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'd307, 1'b0, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    chk("err_sticky", frame_err, 1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("err_cleared", frame_err, 0);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, $urandom, ($urandom % 5) == 0,
          ($urandom % 3) != 0, ($urandom % 16) == 0);
    drain();

    // Reset mid-frame with 5 words stored; effect must be immediate.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(500 + i), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_level", level, 0);
    chk("async_rst_tvalid", m_tvalid, 0);
    chk("async_rst_tready", s_tready, 0);
    chk("async_rst_frames", frames_out, 0);
    repeat (2) idle(1'b0);
    rst_n = 1'b1;
    idle(1'b0);
    idle(1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(600 + i), i == 3, 1'b1, 1'b0);
    drain();
    chk("frames_after_reset", frames_out, 1);
    chk("err_after_reset", frame_err, 0);

    repeat (2) idle(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
